// File: rtl/tape_out_sched.sv
`default_nettype none
// ============================================================================
// Module      : tape_out_sched
// Description : Cassette-output block scheduler. Drives the bit generator
//               through leader bytes, a sync byte, the payload bytes queued
//               in a 4-entry FIFO, and a trailing silence gap.
// Revision    : 1.0 - initial release
// ============================================================================
module tape_out_sched #(
    parameter int unsigned LEADER_LEN  = 256,
    parameter logic [7:0]  LEADER_BYTE = 8'h16,
    parameter logic [7:0]  SYNC_BYTE   = 8'h24,
    parameter int unsigned GAP_CYCLES  = 16000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       go_i,
    input  logic       abort_i,
    input  logic       wr_en_i,
    input  logic [7:0] wr_data_i,
    input  logic       wr_last_i,
    output logic       fifo_full_o,
    output logic [2:0] fifo_count_o,
    output logic       busy_o,
    output logic       underrun_o,
    output logic       block_done_o,
    output logic       gen_start_o,
    output logic [7:0] gen_din_o,
    input  logic       gen_done_i
);

    // Gap counter runs 0 .. GAP_CYCLES-1
    localparam int unsigned      GAP_W       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(GAP_CYCLES - 1);
    localparam logic [9:0]       LEADER_INIT = 10'(LEADER_LEN);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_GAP    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PH_LEADER = 2'd0,
        PH_SYNC   = 2'd1,
        PH_DATA   = 2'd2
    } phase_t;

    // ------------------------------------------------------------------
    // Payload FIFO: {last, data}, circular
    // ------------------------------------------------------------------
    logic [8:0] mem_q [4];
    logic [1:0] wptr_q;
    logic [1:0] rptr_q;
    logic [2:0] count_q;
    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;
    logic [8:0] w_head;

    assign w_full  = (count_q == 3'd4);
    assign w_empty = (count_q == 3'd0);
    // A write against a full FIFO is lost even if a pop frees a slot this cycle
    assign w_push  = wr_en_i & ~w_full & ~abort_i;
    assign w_head  = mem_q[rptr_q];

    // Storage array; no reset needed, validity is tracked by count_q
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wptr_q] <= {wr_last_i, wr_data_i};
        end
    end

    // FIFO pointers and occupancy; abort flushes everything
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q  <= 2'd0;
            rptr_q  <= 2'd0;
            count_q <= 3'd0;
        end else if (abort_i) begin
            wptr_q  <= 2'd0;
            rptr_q  <= 2'd0;
            count_q <= 3'd0;
        end else begin
            if (w_push) begin
                wptr_q <= wptr_q + 2'd1;
            end
            if (w_pop) begin
                rptr_q <= rptr_q + 2'd1;
            end
            count_q <= count_q + {2'b00, w_push} - {2'b00, w_pop};
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t           state_q,      state_d;
    phase_t           phase_q,      phase_d;
    logic [9:0]       lcnt_q,       lcnt_d;
    logic [GAP_W-1:0] gcnt_q,       gcnt_d;
    logic             stall_q,      stall_d;
    logic             last_q,       last_d;
    logic             underrun_q,   underrun_d;
    logic             block_done_q, block_done_d;
    logic             gen_start_q,  gen_start_d;
    logic [7:0]       gen_din_q,    gen_din_d;
    logic             w_fire;

    // Next-state logic. A "fire" loads the byte and start pulse at the same
    // edge that enters the ISSUE cycle, so both are visible during ISSUE.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        lcnt_d       = lcnt_q;
        gcnt_d       = gcnt_q;
        stall_d      = stall_q;
        last_d       = last_q;
        underrun_d   = underrun_q;
        block_done_d = 1'b0;
        gen_start_d  = 1'b0;
        gen_din_d    = gen_din_q;
        w_pop        = 1'b0;
        w_fire       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (go_i) begin
                    state_d    = ST_ISSUE;
                    lcnt_d     = LEADER_INIT;
                    phase_d    = (LEADER_LEN == 0) ? PH_SYNC : PH_LEADER;
                    underrun_d = 1'b0;
                    w_fire     = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (stall_q) begin
                    // Waiting on an empty FIFO: resume as soon as data exists
                    underrun_d = 1'b1;
                    if (!w_empty) begin
                        stall_d = 1'b0;
                        w_fire  = 1'b1;
                    end
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (gen_done_i) begin
                    case (phase_q)
                        PH_LEADER: begin
                            lcnt_d  = lcnt_q - 10'd1;
                            if (lcnt_q == 10'd1) begin
                                phase_d = PH_SYNC;
                            end
                            state_d = ST_ISSUE;
                            w_fire  = 1'b1;
                        end
                        PH_SYNC: begin
                            phase_d = PH_DATA;
                            state_d = ST_ISSUE;
                            if (w_empty) begin
                                stall_d = 1'b1;
                            end else begin
                                w_fire = 1'b1;
                            end
                        end
                        default: begin
                            if (last_q) begin
                                state_d = ST_GAP;
                                gcnt_d  = '0;
                            end else begin
                                state_d = ST_ISSUE;
                                if (w_empty) begin
                                    stall_d = 1'b1;
                                end else begin
                                    w_fire = 1'b1;
                                end
                            end
                        end
                    endcase
                end
            end
            ST_GAP: begin
                if (gcnt_q == GAP_LAST) begin
                    state_d      = ST_IDLE;
                    block_done_d = 1'b1;
                end else begin
                    gcnt_d = gcnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_fire) begin
            gen_start_d = 1'b1;
            case (phase_d)
                PH_LEADER: gen_din_d = LEADER_BYTE;
                PH_SYNC:   gen_din_d = SYNC_BYTE;
                default: begin
                    gen_din_d = w_head[7:0];
                    last_d    = w_head[8];
                    w_pop     = 1'b1;
                end
            endcase
        end

        // Abort wins over everything; the byte on gen_din and underrun stay
        if (abort_i) begin
            state_d      = ST_IDLE;
            phase_d      = phase_q;
            lcnt_d       = lcnt_q;
            stall_d      = 1'b0;
            last_d       = last_q;
            underrun_d   = underrun_q;
            block_done_d = 1'b0;
            gen_start_d  = 1'b0;
            gen_din_d    = gen_din_q;
            w_pop        = 1'b0;
        end
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            phase_q      <= PH_LEADER;
            lcnt_q       <= 10'd0;
            gcnt_q       <= '0;
            stall_q      <= 1'b0;
            last_q       <= 1'b0;
            underrun_q   <= 1'b0;
            block_done_q <= 1'b0;
            gen_start_q  <= 1'b0;
            gen_din_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            lcnt_q       <= lcnt_d;
            gcnt_q       <= gcnt_d;
            stall_q      <= stall_d;
            last_q       <= last_d;
            underrun_q   <= underrun_d;
            block_done_q <= block_done_d;
            gen_start_q  <= gen_start_d;
            gen_din_q    <= gen_din_d;
        end
    end

    assign fifo_full_o  = w_full;
    assign fifo_count_o = count_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign underrun_o   = underrun_q;
    assign block_done_o = block_done_q;
    assign gen_start_o  = gen_start_q;
    assign gen_din_o    = gen_din_q;

endmodule
`default_nettype wire

// File: tb/tb_tape_out_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_tape_out_sched
// Description : Self-checking bench for tape_out_sched. Two instances: one
//               with a 3-byte leader, one with no leader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tape_out_sched;

    localparam int         G  = 40;
    localparam logic [7:0] LB = 8'h16;
    localparam logic [7:0] SB = 8'h24;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [1:0] go       = 2'b00;
    logic [1:0] abort    = 2'b00;
    logic [1:0] wr_en    = 2'b00;
    logic [1:0] wr_last  = 2'b00;
    logic [1:0] gen_done = 2'b11;
    logic [7:0] wr_data [2];
    wire  [1:0] full, busy, und, bdone, gstart;
    wire  [2:0] fcnt [2];
    wire  [7:0] gdin [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tape_out_sched #(.LEADER_LEN(3), .GAP_CYCLES(G)) dut (
        .clk_i(clk), .reset_i(rst), .go_i(go[0]), .abort_i(abort[0]),
        .wr_en_i(wr_en[0]), .wr_data_i(wr_data[0]), .wr_last_i(wr_last[0]),
        .fifo_full_o(full[0]), .fifo_count_o(fcnt[0]), .busy_o(busy[0]),
        .underrun_o(und[0]), .block_done_o(bdone[0]), .gen_start_o(gstart[0]),
        .gen_din_o(gdin[0]), .gen_done_i(gen_done[0])
    );

    tape_out_sched #(.LEADER_LEN(0), .GAP_CYCLES(G)) dut0 (
        .clk_i(clk), .reset_i(rst), .go_i(go[1]), .abort_i(abort[1]),
        .wr_en_i(wr_en[1]), .wr_data_i(wr_data[1]), .wr_last_i(wr_last[1]),
        .fifo_full_o(full[1]), .fifo_count_o(fcnt[1]), .busy_o(busy[1]),
        .underrun_o(und[1]), .block_done_o(bdone[1]), .gen_start_o(gstart[1]),
        .gen_din_o(gdin[1]), .gen_done_i(gen_done[1])
    );

    // ------------------------------------------------------------------
    // Generator model and monitor (observes mid-cycle on the falling edge)
    // ------------------------------------------------------------------
    int         cyc = 0;
    int         dly       [2] = '{20, 10};
    int         cnt       [2] = '{0, 0};
    int         nstart    [2] = '{0, 0};
    int         ndone     [2] = '{0, 0};
    int         last_rise [2] = '{0, 0};
    int         done_cyc  [2] = '{0, 0};
    int         gap_err   [2] = '{0, 0};
    logic       follow    [2] = '{1'b0, 1'b0};
    logic       bd_busy   [2] = '{1'b0, 1'b0};
    logic [7:0] got0 [$];
    logic [7:0] got1 [$];
    logic [7:0] pay_q [$];
    logic [7:0] exp_q [$];

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                gen_done[k] = 1'b1;
                cnt[k]      = 0;
                follow[k]   = 1'b0;
            end else if (gstart[k]) begin
                if (follow[k] && cyc != last_rise[k] + 1) gap_err[k]++;
                follow[k]   = 1'b1;
                gen_done[k] = 1'b0;
                cnt[k]      = dly[k];
                nstart[k]++;
                if (k == 0) got0.push_back(gdin[k]);
                else        got1.push_back(gdin[k]);
            end else if (cnt[k] > 0) begin
                cnt[k]--;
                if (cnt[k] == 0) begin
                    gen_done[k]  = 1'b1;
                    last_rise[k] = cyc;
                end
            end
            if (bdone[k]) begin
                ndone[k]++;
                done_cyc[k] = cyc;
                bd_busy[k]  = busy[k];
            end
        end
    end

    // Reference byte stream of one block: leader run, sync, payload
    task automatic build_exp(input int leader);
        exp_q.delete();
        for (int i = 0; i < leader; i++) exp_q.push_back(LB);
        exp_q.push_back(SB);
        foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
    endtask

    // -1 when the captured stream equals the reference, -2 on length
    // mismatch, otherwise the first differing index
    function automatic int seq_diff(input int k);
        logic [7:0] g [$];
        if (k == 0) g = got0;
        else        g = got1;
        if (g.size() != exp_q.size()) return -2;
        foreach (g[i]) if (g[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int k, input logic [7:0] d, input logic l);
        wr_en[k] = 1'b1; wr_data[k] = d; wr_last[k] = l;
        step();
        wr_en[k] = 1'b0; wr_last[k] = 1'b0;
    endtask

    task automatic wait_block(input int k, input int base);
        int n = 0;
        while (ndone[k] == base && n < 5000) begin step(); n++; end
        tests++;
        if (ndone[k] == base) begin
            fails++;
            $display("FAIL block_done_timeout dut%0d: none after %0d cycles, required within 5000", k, n);
        end
    endtask

    task automatic wait_starts(input int k, input int target);
        int n = 0;
        while (nstart[k] < target && n < 3000) begin step(); n++; end
        tests++;
        if (nstart[k] < target) begin
            fails++;
            $display("FAIL start_timeout dut%0d: %0d starts, required %0d", k, nstart[k], target);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({full, busy, und, bdone, gstart, fcnt[0], fcnt[1], gdin[0], gdin[1]} !== '0) begin
            fails++;
            $display("FAIL reset_held: outputs %h, required 0",
                     {full, busy, und, bdone, gstart, fcnt[0], fcnt[1], gdin[0], gdin[1]});
        end
        #2 rst = 1'b0;
        repeat (2) step();
        tests++;
        if ({full, busy, und, bdone, gstart, fcnt[0], fcnt[1], gdin[0], gdin[1]} !== '0) begin
            fails++;
            $display("FAIL reset_released: outputs %h, required 0",
                     {full, busy, und, bdone, gstart, fcnt[0], fcnt[1], gdin[0], gdin[1]});
        end
    endtask

    task automatic test_basic();
        int sb, db, eb, d;
        dly[0] = 20;
        pay_q = '{8'hA5, 8'h3C};
        wr(0, 8'hA5, 1'b0);
        wr(0, 8'h3C, 1'b1);
        tests++;
        if (fcnt[0] !== 3'd2) begin fails++; $display("FAIL basic_preload_count: got %0d, required 2", fcnt[0]); end
        got0.delete(); sb = nstart[0]; db = ndone[0]; eb = gap_err[0]; follow[0] = 1'b0;
        go[0] = 1'b1; step(); go[0] = 1'b0;
        tests++;
        if ({busy[0], gstart[0], gdin[0]} !== {1'b1, 1'b1, LB}) begin
            fails++;
            $display("FAIL basic_first_issue: busy/start/din %b/%b/%h, required 1/1/%h", busy[0], gstart[0], gdin[0], LB);
        end
        wait_block(0, db);
        build_exp(3);
        d = seq_diff(0);
        tests++;
        if (d != -1) begin fails++; $display("FAIL basic_sequence: diff at %0d (got %0d bytes), required %0d bytes", d, got0.size(), exp_q.size()); end
        tests++;
        if (nstart[0] - sb != 6) begin fails++; $display("FAIL basic_start_count: got %0d, required 6", nstart[0] - sb); end
        tests++;
        if (done_cyc[0] != last_rise[0] + G + 1) begin
            fails++; $display("FAIL basic_done_time: cycle %0d, required %0d", done_cyc[0], last_rise[0] + G + 1);
        end
        tests++;
        if (gap_err[0] != eb) begin fails++; $display("FAIL basic_byte_spacing: %0d late starts, required 0", gap_err[0] - eb); end
        tests++;
        if ({und[0], bd_busy[0], bdone[0]} !== 3'b000) begin
            fails++; $display("FAIL basic_end_flags: und/busy_at_done/bdone %b, required 000", {und[0], bd_busy[0], bdone[0]});
        end
        repeat (G) step();
        tests++;
        if (ndone[0] - db != 1) begin fails++; $display("FAIL basic_done_count: got %0d, required 1", ndone[0] - db); end
    endtask

    task automatic test_underrun();
        int sb, db, d;
        dly[0] = 20;
        pay_q = '{8'hA5, 8'h3C};
        wr(0, 8'hA5, 1'b0);
        got0.delete(); sb = nstart[0]; db = ndone[0];
        go[0] = 1'b1; step(); go[0] = 1'b0;
        wait_starts(0, sb + 5);
        repeat (200) step();
        tests++;
        if ({und[0], busy[0], gstart[0]} !== 3'b110 || nstart[0] - sb != 5) begin
            fails++;
            $display("FAIL underrun_stall: und/busy/start %b starts %0d, required 110 and 5", {und[0], busy[0], gstart[0]}, nstart[0] - sb);
        end
        wr(0, 8'h3C, 1'b1);
        wait_block(0, db);
        build_exp(3);
        d = seq_diff(0);
        tests++;
        if (d != -1) begin fails++; $display("FAIL underrun_sequence: diff at %0d, required none", d); end
        tests++;
        if (und[0] !== 1'b1) begin fails++; $display("FAIL underrun_sticky: got %b, required 1", und[0]); end
    endtask

    task automatic test_overflow();
        int db, d;
        dly[0] = $urandom_range(2, 25);
        pay_q.delete();
        for (int i = 0; i < 4; i++) pay_q.push_back(8'($urandom));
        for (int i = 0; i < 4; i++) wr(0, pay_q[i], i == 3);
        tests++;
        if ({full[0], fcnt[0]} !== {1'b1, 3'd4}) begin fails++; $display("FAIL ovf_full: full/count %b/%0d, required 1/4", full[0], fcnt[0]); end
        wr(0, 8'($urandom), 1'b0);
        tests++;
        if ({full[0], fcnt[0]} !== {1'b1, 3'd4}) begin fails++; $display("FAIL ovf_drop: full/count %b/%0d, required 1/4", full[0], fcnt[0]); end
        got0.delete(); db = ndone[0];
        go[0] = 1'b1; step(); go[0] = 1'b0;
        tests++;
        if (und[0] !== 1'b0) begin fails++; $display("FAIL ovf_underrun_clear: got %b, required 0", und[0]); end
        wait_block(0, db);
        build_exp(3);
        d = seq_diff(0);
        tests++;
        if (d != -1) begin fails++; $display("FAIL ovf_sequence: diff at %0d, required none", d); end
        tests++;
        if (fcnt[0] !== 3'd0) begin fails++; $display("FAIL ovf_leftover: count %0d, required 0", fcnt[0]); end
    endtask

    task automatic test_abort();
        int sb, db, d;
        dly[0] = 20;
        wr(0, 8'h77, 1'b1);
        got0.delete(); sb = nstart[0]; db = ndone[0];
        go[0] = 1'b1; step(); go[0] = 1'b0;
        wait_starts(0, sb + 2);
        step();
        abort[0] = 1'b1; step(); abort[0] = 1'b0;
        tests++;
        if ({busy[0], gstart[0], fcnt[0], gdin[0]} !== {1'b0, 1'b0, 3'd0, LB}) begin
            fails++;
            $display("FAIL abort_state: busy/start/count/din %b/%b/%0d/%h, required 0/0/0/%h", busy[0], gstart[0], fcnt[0], gdin[0], LB);
        end
        repeat (G + 60) step();
        tests++;
        if (ndone[0] != db || nstart[0] - sb != 2) begin
            fails++; $display("FAIL abort_quiet: done %0d starts %0d, required 0 and 2", ndone[0] - db, nstart[0] - sb);
        end
        pay_q = '{8'h77};
        wr(0, 8'h77, 1'b1);
        got0.delete();
        go[0] = 1'b1; step(); go[0] = 1'b0;
        wait_block(0, db);
        build_exp(3);
        d = seq_diff(0);
        tests++;
        if (d != -1) begin fails++; $display("FAIL abort_restart_sequence: diff at %0d, required none", d); end
    endtask

    task automatic test_leader0();
        int sb, db;
        dly[1] = 10;
        wr(1, 8'h00, 1'b1);
        got1.delete(); sb = nstart[1]; db = ndone[1];
        go[1] = 1'b1; step(); go[1] = 1'b0;
        tests++;
        if ({gstart[1], gdin[1]} !== {1'b1, SB}) begin fails++; $display("FAIL l0_first: start/din %b/%h, required 1/%h", gstart[1], gdin[1], SB); end
        wait_starts(1, sb + 2);
        tests++;
        if (got1.size() != 2 || got1[got1.size() - 1] !== 8'h00) begin
            fails++; $display("FAIL l0_second: %0d bytes, required 2 ending 00", got1.size());
        end
        repeat (15) step();
        go[1] = 1'b1; step(); go[1] = 1'b0;
        wait_block(1, db);
        repeat (G + 30) step();
        tests++;
        if (ndone[1] - db != 1 || nstart[1] - sb != 2 || busy[1] !== 1'b0) begin
            fails++;
            $display("FAIL l0_gap_go: done %0d starts %0d busy %b, required 1, 2, 0", ndone[1] - db, nstart[1] - sb, busy[1]);
        end
    endtask

    task automatic test_random();
        int n, db, eb, d;
        for (int r = 0; r < 6; r++) begin
            dly[0] = $urandom_range(2, 25);
            n = $urandom_range(1, 4);
            pay_q.delete();
            for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
            for (int i = 0; i < n; i++) wr(0, pay_q[i], i == n - 1);
            got0.delete(); db = ndone[0]; eb = gap_err[0]; follow[0] = 1'b0;
            go[0] = 1'b1; step(); go[0] = 1'b0;
            wait_block(0, db);
            build_exp(3);
            d = seq_diff(0);
            tests++;
            if (d != -1) begin fails++; $display("FAIL rand%0d_sequence: diff at %0d (n=%0d), required none", r, d, n); end
            tests++;
            if (done_cyc[0] != last_rise[0] + G + 1 || gap_err[0] != eb) begin
                fails++;
                $display("FAIL rand%0d_timing: done %0d late %0d, required %0d and 0", r, done_cyc[0], gap_err[0] - eb, last_rise[0] + G + 1);
            end
        end
    endtask

    task automatic test_async_reset();
        int sb;
        dly[0] = 20;
        wr(0, 8'hA5, 1'b0);
        wr(0, 8'h3C, 1'b1);
        got0.delete(); sb = nstart[0];
        go[0] = 1'b1; step(); go[0] = 1'b0;
        wait_starts(0, sb + 5);
        repeat (3) step();
        #2 rst = 1'b1; go[0] = 1'b1;
        #1;
        tests++;
        if ({full[0], busy[0], und[0], bdone[0], gstart[0], fcnt[0], gdin[0]} !== '0) begin
            fails++;
            $display("FAIL async_reset: outputs %h, required 0", {full[0], busy[0], und[0], bdone[0], gstart[0], fcnt[0], gdin[0]});
        end
        repeat (3) @(posedge clk);
        #3 rst = 1'b0; go[0] = 1'b0;
        repeat (2) step();
        tests++;
        if ({busy[0], gstart[0]} !== 2'b00) begin fails++; $display("FAIL reset_go_ignored: busy/start %b, required 00", {busy[0], gstart[0]}); end
    endtask

    initial begin
        wr_data[0] = 8'h00;
        wr_data[1] = 8'h00;
        test_reset();
        test_basic();
        test_underrun();
        test_overflow();
        test_abort();
        test_leader0();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "global time limit reached");
    end

endmodule
`default_nettype wire
